// File: rtl/spr_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// spr_writeback_arbiter
//
// Serializes finished SPR results from UNITS execution units onto the single
// write port of the special-purpose register file (XER/LR/CTR), and broadcasts
// every accepted result with its reservation-station ID on the result bus.
// Round-robin arbitration; one registered output stage; results aimed at an
// unsupported SPR are dropped from the register-file write but still broadcast
// (so waiting reservation stations never deadlock) and raise a sticky error.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   unit_valid[i]     unit i presents a result (held until unit_ready[i])
//   unit_ready[i]     unit i result accepted this cycle (combinational)
//   unit_addr[i]      destination SPR number
//   unit_value[i]     result value
//   unit_rs_id[i]     producing reservation-station ID
//   write_addr/_enable/_value   register-file write port (registered)
//   cdb_valid/_rs_id/_value     result bus (registered)
//   err_illegal_addr  sticky: a result targeted an unsupported SPR
//   err_unit          unit that caused the first illegal-address error
//   write_count       committed register-file writes (wraps)
// -----------------------------------------------------------------------------
module spr_writeback_arbiter #(
  parameter int UNITS       = 3,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [0:UNITS-1]                     unit_valid,
  output logic [0:UNITS-1]                     unit_ready,
  input  logic [0:UNITS-1][0:9]                unit_addr,
  input  logic [0:UNITS-1][0:31]               unit_value,
  input  logic [0:UNITS-1][0:RS_ID_WIDTH-1]    unit_rs_id,
  output logic [0:9]                           write_addr,
  output logic                                 write_enable,
  output logic [0:31]                          write_value,
  output logic                                 cdb_valid,
  output logic [0:RS_ID_WIDTH-1]               cdb_rs_id,
  output logic [0:31]                          cdb_value,
  output logic                                 err_illegal_addr,
  output logic [0:$clog2(UNITS)-1]             err_unit,
  output logic [0:31]                          write_count
);

  localparam int PTR_W = $clog2(UNITS);

  localparam logic [0:9] SPR_XER = 10'd1;
  localparam logic [0:9] SPR_LR  = 10'd8;
  localparam logic [0:9] SPR_CTR = 10'd9;

  logic [PTR_W-1:0]       rr_ptr_ff;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [PTR_W:0]         cand;
  logic                   grant_any;
  logic                   xfer;
  logic                   sel_legal;
  logic [0:9]             sel_addr;
  logic [0:31]            sel_value;
  logic [0:RS_ID_WIDTH-1] sel_rs_id;

  // Round-robin search: candidates rr_ptr_ff, rr_ptr_ff+1, ... wrapping at
  // UNITS-1. cand has one spare bit so the sum cannot overflow before the wrap
  // subtraction.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < UNITS; k++) begin
      cand = {1'b0, rr_ptr_ff} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(UNITS)) begin
        cand = cand - (PTR_W+1)'(UNITS);
      end
      if (!grant_any && unit_valid[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Ready is suppressed while reset is asserted so no unit believes a result
  // was accepted that the reset is about to throw away.
  assign xfer = grant_any && !rst;

  always_comb begin
    unit_ready = '0;
    if (xfer) begin
      unit_ready[grant_idx] = 1'b1;
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);

  assign sel_addr  = unit_addr[grant_idx];
  assign sel_value = unit_value[grant_idx];
  assign sel_rs_id = unit_rs_id[grant_idx];
  assign sel_legal = (sel_addr == SPR_XER) || (sel_addr == SPR_LR) ||
                     (sel_addr == SPR_CTR);

  // Arbitration pointer: advances past the winner, holds when idle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block or statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_ff <= '0;
    end else if (grant_any) begin
      rr_ptr_ff <= next_ptr;
    end
  end

  // Output stage. Valid/enable strobes last exactly one cycle per transfer;
  // address and data fields simply hold when nothing is transferred.
  // NOTE: the data fields are reset too, because every output must read 0
  // during reset; they are plain flops, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_value  <= '0;
      cdb_valid    <= 1'b0;
      cdb_rs_id    <= '0;
      cdb_value    <= '0;
    end else begin
      write_enable <= xfer && sel_legal;
      cdb_valid    <= xfer;
      if (xfer) begin
        write_addr  <= sel_addr;
        write_value <= sel_value;
        cdb_rs_id   <= sel_rs_id;
        cdb_value   <= sel_value;
      end
    end
  end

  // Sticky error; err_unit latches only the first offender.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal_addr <= 1'b0;
      err_unit         <= '0;
    end else if (xfer && !sel_legal && !err_illegal_addr) begin
      err_illegal_addr <= 1'b1;
      err_unit         <= grant_idx;
    end
  end

  // Counts writes actually presented to the register file (wraps naturally).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count <= '0;
    end else if (write_enable) begin
      write_count <= write_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_spr_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spr_writeback_arbiter
//
// Directed bench for spr_writeback_arbiter (UNITS = 3, RS_ID_WIDTH = 5).
// Inputs change 1 time unit after the rising edge; unit_ready is sampled 1 unit
// after the inputs settle and registered outputs 1 unit after the edge.
// -----------------------------------------------------------------------------
module tb_spr_writeback_arbiter;

  localparam int UNITS = 3;
  localparam int RSW   = 5;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [0:UNITS-1]           unit_valid;
  logic [0:UNITS-1]           unit_ready;
  logic [0:UNITS-1][0:9]      unit_addr;
  logic [0:UNITS-1][0:31]     unit_value;
  logic [0:UNITS-1][0:RSW-1]  unit_rs_id;
  logic [0:9]                 write_addr;
  logic                       write_enable;
  logic [0:31]                write_value;
  logic                       cdb_valid;
  logic [0:RSW-1]             cdb_rs_id;
  logic [0:31]                cdb_value;
  logic                       err_illegal_addr;
  logic [0:1]                 err_unit;
  logic [0:31]                write_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spr_writeback_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
    .clk              (clk),
    .rst              (rst),
    .unit_valid       (unit_valid),
    .unit_ready       (unit_ready),
    .unit_addr        (unit_addr),
    .unit_value       (unit_value),
    .unit_rs_id       (unit_rs_id),
    .write_addr       (write_addr),
    .write_enable     (write_enable),
    .write_value      (write_value),
    .cdb_valid        (cdb_valid),
    .cdb_rs_id        (cdb_rs_id),
    .cdb_value        (cdb_value),
    .err_illegal_addr (err_illegal_addr),
    .err_unit         (err_unit),
    .write_count      (write_count)
  );

  // Every output concatenated, for the all-zero reset comparisons.
  logic [0:118] all_out;
  assign all_out = {unit_ready, write_addr, write_enable, write_value, cdb_valid,
                    cdb_rs_id, cdb_value, err_illegal_addr, err_unit, write_count};

  // A unit that was valid but not accepted must still be valid next edge.
  logic [0:UNITS-1] pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < UNITS; i++) begin
        if (pend[i] && !unit_valid[i]) begin
          errors++;
          $display("FAIL protocol: unit %0d dropped valid without ready", i);
        end
      end
      pend <= unit_valid & ~unit_ready;
    end
  end

  function automatic logic [0:31] mkval(input int u, input int s);
    return 32'hA000_0000 + 32'(u) * 32'h0001_0000 + 32'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    unit_valid = 3'b111;
    unit_addr  = '0;
    unit_value = '0;
    unit_rs_id = '0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL reset_hold: outputs %h, want 0", all_out);
      end
      step();
    end
    rst        = 1'b0;
    unit_valid = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs %h, want 0", c, all_out);
      end
    end
  endtask

  task automatic test_single();
    unit_valid    = 3'b010;
    unit_addr[1]  = 10'd8;
    unit_value[1] = 32'hDEAD_BEEF;
    unit_rs_id[1] = 5'd3;
    #1;
    checks++;
    if (unit_ready !== 3'b010) begin
      errors++;
      $display("FAIL single_ready: got %b want 010", unit_ready);
    end
    step();
    unit_valid = '0;
    checks++;
    if ({write_enable, write_addr, write_value, cdb_valid, cdb_rs_id, cdb_value, write_count} !==
        {1'b1, 10'd8, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'd0}) begin
      errors++;
      $display("FAIL single_out: we=%b addr=%0d val=%h cv=%b rs=%0d cval=%h cnt=%0d, want 1 8 deadbeef 1 3 deadbeef 0",
               write_enable, write_addr, write_value, cdb_valid, cdb_rs_id, cdb_value, write_count);
    end
    step();
    checks++;
    if ({write_enable, cdb_valid, write_addr, write_count} !== {1'b0, 1'b0, 10'd8, 32'd1}) begin
      errors++;
      $display("FAIL single_after: we=%b cv=%b addr=%0d cnt=%0d, want 0 0 8 1",
               write_enable, cdb_valid, write_addr, write_count);
    end
  endtask

  // Pointer is 2 here (last grant went to unit 1); unit 1 alone still wins.
  task automatic test_reset_mid();
    unit_valid    = 3'b010;
    unit_addr[1]  = 10'd8;
    unit_value[1] = 32'h0BAD_F00D;
    unit_rs_id[1] = 5'd6;
    #1;
    checks++;
    if (unit_ready !== 3'b010) begin
      errors++;
      $display("FAIL mid_ready: got %b want 010", unit_ready);
    end
    step();
    unit_valid = '0;
    checks++;
    if ({write_enable, write_count} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL mid_pre: we=%b cnt=%0d, want 1 1", write_enable, write_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset: outputs %h, want 0", all_out);
    end
    step();
    rst = 1'b0;
  endtask

  // Starts right after a reset, so the first grant going to unit 0 shows the
  // pointer was cleared (it was 2 before the reset).
  task automatic test_round_robin();
    logic [0:2] vtab [6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b001};
    int         gtab [6] = '{0, 1, 2, 0, 1, 2};
    int         seq  [3] = '{0, 0, 0};
    logic [0:2]  exp_r;
    logic [0:9]  exp_addr;
    logic [0:31] exp_val;
    logic [0:4]  exp_rs;
    int          g_prev = 0;
    for (int u = 0; u < UNITS; u++) begin
      unit_value[u] = mkval(u, 0);
      unit_rs_id[u] = 5'(10 + u);
    end
    unit_addr[0] = 10'd1;
    unit_addr[1] = 10'd8;
    unit_addr[2] = 10'd9;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        step();
        checks++;
        if ({write_enable, cdb_valid, write_addr, write_value, cdb_rs_id, cdb_value} !==
            {1'b1, 1'b1, exp_addr, exp_val, exp_rs, exp_val}) begin
          errors++;
          $display("FAIL rr_out c%0d: we=%b cv=%b addr=%0d val=%h rs=%0d, want 1 1 %0d %h %0d",
                   c, write_enable, cdb_valid, write_addr, write_value, cdb_rs_id,
                   exp_addr, exp_val, exp_rs);
        end
        seq[g_prev]++;
        unit_value[g_prev] = mkval(g_prev, seq[g_prev]);
      end
      if (c < 6) begin
        unit_valid = vtab[c];
        #1;
        exp_r = '0;
        exp_r[gtab[c]] = 1'b1;
        checks++;
        if (unit_ready !== exp_r) begin
          errors++;
          $display("FAIL rr_grant c%0d: ready %b, want %b", c, unit_ready, exp_r);
        end
        g_prev   = gtab[c];
        exp_addr = unit_addr[g_prev];
        exp_val  = unit_value[g_prev];
        exp_rs   = unit_rs_id[g_prev];
      end else begin
        unit_valid = '0;
      end
    end
    step();
    checks++;
    if ({write_enable, cdb_valid, write_count} !== {1'b0, 1'b0, 32'd6}) begin
      errors++;
      $display("FAIL rr_end: we=%b cv=%b cnt=%0d, want 0 0 6", write_enable, cdb_valid, write_count);
    end
  endtask

  // Unit 0 always requesting; unit 2 joins in cycle 1 and is granted at once,
  // unit 1 joins in cycle 2. Unit 2's second result waits exactly UNITS-1 grants.
  task automatic test_fairness();
    logic [0:2] vtab [5] = '{3'b100, 3'b101, 3'b111, 3'b011, 3'b001};
    int         gtab [5] = '{0, 2, 0, 1, 2};
    int         seq  [3] = '{5, 5, 5};
    logic [0:2]  exp_r;
    logic [0:31] exp_val;
    int          g_prev = 0;
    for (int u = 0; u < UNITS; u++) begin
      unit_addr[u]  = 10'd8;
      unit_value[u] = mkval(u, 5);
    end
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin
        step();
        checks++;
        if ({write_enable, write_value} !== {1'b1, exp_val}) begin
          errors++;
          $display("FAIL fair_out c%0d: we=%b val=%h, want 1 %h", c, write_enable, write_value, exp_val);
        end
        seq[g_prev]++;
        unit_value[g_prev] = mkval(g_prev, seq[g_prev]);
      end
      if (c < 5) begin
        unit_valid = vtab[c];
        #1;
        exp_r = '0;
        exp_r[gtab[c]] = 1'b1;
        checks++;
        if (unit_ready !== exp_r) begin
          errors++;
          $display("FAIL fair_grant c%0d: ready %b, want %b", c, unit_ready, exp_r);
        end
        g_prev  = gtab[c];
        exp_val = unit_value[g_prev];
      end else begin
        unit_valid = '0;
      end
    end
    step();
    checks++;
    if (write_count !== 32'd11) begin
      errors++;
      $display("FAIL fair_count: cnt=%0d, want 11", write_count);
    end
  endtask

  task automatic test_illegal();
    // pointer is 0; unit 2 alone
    unit_valid    = 3'b001;
    unit_addr[2]  = 10'd5;
    unit_value[2] = 32'h0000_0012;
    unit_rs_id[2] = 5'd7;
    #1;
    checks++;
    if (unit_ready !== 3'b001) begin
      errors++;
      $display("FAIL ill_ready: got %b want 001", unit_ready);
    end
    step();
    unit_valid = '0;
    checks++;
    if ({write_enable, cdb_valid, cdb_rs_id, cdb_value, err_illegal_addr, err_unit} !==
        {1'b0, 1'b1, 5'd7, 32'h12, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL ill_out: we=%b cv=%b rs=%0d cval=%h err=%b eu=%0d, want 0 1 7 12 1 2",
               write_enable, cdb_valid, cdb_rs_id, cdb_value, err_illegal_addr, err_unit);
    end
    // second illegal result, from unit 0 (pointer now 0)
    unit_valid    = 3'b100;
    unit_addr[0]  = 10'h3FF;
    unit_value[0] = 32'h0000_0034;
    unit_rs_id[0] = 5'd1;
    #1;
    checks++;
    if (unit_ready !== 3'b100) begin
      errors++;
      $display("FAIL ill2_ready: got %b want 100", unit_ready);
    end
    step();
    unit_valid = '0;
    checks++;
    if ({write_enable, cdb_valid, cdb_rs_id, err_illegal_addr, err_unit, write_count} !==
        {1'b0, 1'b1, 5'd1, 1'b1, 2'd2, 32'd11}) begin
      errors++;
      $display("FAIL ill2_out: we=%b cv=%b rs=%0d err=%b eu=%0d cnt=%0d, want 0 1 1 1 2 11",
               write_enable, cdb_valid, cdb_rs_id, err_illegal_addr, err_unit, write_count);
    end
    step();
    checks++;
    if ({err_illegal_addr, err_unit, write_count, cdb_valid} !== {1'b1, 2'd2, 32'd11, 1'b0}) begin
      errors++;
      $display("FAIL ill_sticky: err=%b eu=%0d cnt=%0d cv=%b, want 1 2 11 0",
               err_illegal_addr, err_unit, write_count, cdb_valid);
    end
  endtask

  task automatic test_count_wrap();
    force dut.write_count = 32'hFFFF_FFFF;
    step();
    release dut.write_count;
    // pointer is 1; unit 1 writes CTR
    unit_valid    = 3'b010;
    unit_addr[1]  = 10'd9;
    unit_value[1] = 32'h5555_AAAA;
    unit_rs_id[1] = 5'd4;
    #1;
    checks++;
    if (unit_ready !== 3'b010) begin
      errors++;
      $display("FAIL wrap_ready: got %b want 010", unit_ready);
    end
    step();
    unit_valid = '0;
    checks++;
    if ({write_enable, write_addr, write_value, write_count} !==
        {1'b1, 10'd9, 32'h5555_AAAA, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_write: we=%b addr=%0d val=%h cnt=%h, want 1 9 5555aaaa ffffffff",
               write_enable, write_addr, write_value, write_count);
    end
    step();
    checks++;
    if ({write_enable, write_count} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL wrap_count: we=%b cnt=%h, want 0 00000000", write_enable, write_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_fairness();
    test_illegal();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
